// File: rtl/qsched_pkg.sv
// Shared constants, scheduler state encoding and the round-robin pick helper
// used by the queue scheduler and its per-queue shift buffers.
package qsched_pkg;

  localparam int NQ      = 4;
  localparam int DEPTH   = 6;
  localparam int PAY_W   = 2;
  localparam int QID_W   = 2;
  localparam int CNT_W   = 3;
  localparam int ENTRY_W = 3;
  localparam int IMAGE_W = DEPTH * ENTRY_W;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic             found;
    logic [QID_W-1:0] qid;
  } grant_t;

  // Search last+1, last+2, ... wrapping; the nearest non-empty queue wins.
  function automatic grant_t rr_pick(input logic [NQ-1:0]    nonempty,
                                     input logic [QID_W-1:0] last);
    grant_t           g;
    logic [QID_W-1:0] idx;
    g = '0;
    for (int k = NQ; k >= 1; k--) begin
      idx = last + QID_W'(k);
      if (nonempty[idx]) begin
        g.found = 1'b1;
        g.qid   = idx;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/shift_queue.sv
// One scheduler queue: a shift-down buffer, slot 0 oldest. A push into a full
// queue without a same-edge pop discards the oldest entry and sets a sticky drop.
module shift_queue
  import qsched_pkg::*;
#(
  parameter int DEPTH = qsched_pkg::DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [PAY_W-1:0]           i_data,
  input  logic                       i_pop,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [CNT_W-1:0]           o_count,
  output logic [PAY_W-1:0]           o_head,
  output logic [DEPTH*ENTRY_W-1:0]   o_image,
  output logic                       o_drop
);

  logic [PAY_W-1:0] r_slot [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic             r_drop;

  logic [PAY_W-1:0] w_slot_nxt [DEPTH];
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_drop_nxt;
  logic [PAY_W-1:0] w_shift [DEPTH];

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_slot[0];
  assign o_drop  = r_drop;

  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) w_shift[i] = r_slot[i+1];
    w_shift[DEPTH-1] = r_slot[DEPTH-1];
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_slot_nxt  = r_slot;
    w_count_nxt = r_count;
    w_drop_nxt  = r_drop;
    if (i_pop && !i_push) begin
      w_slot_nxt  = w_shift;
      w_count_nxt = r_count - CNT_W'(1);
    end else if (i_pop && i_push) begin
      w_slot_nxt                          = w_shift;
      w_slot_nxt[r_count - CNT_W'(1)]     = i_data;
    end else if (i_push && !o_full) begin
      w_slot_nxt[r_count] = i_data;
      w_count_nxt         = r_count + CNT_W'(1);
    end else if (i_push) begin
      w_slot_nxt           = w_shift;
      w_slot_nxt[DEPTH-1]  = i_data;
      w_drop_nxt           = 1'b1;
    end
  end

  // NOTE: the storage is reset along with the count because the images must
  // read all-zero during reset; sequential state is written with <= only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
      r_count <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_slot  <= w_slot_nxt;
      r_count <= w_count_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  // Slots at or above the occupancy read as empty regardless of stale payload.
  always_comb begin
    o_image = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < r_count) o_image[ENTRY_W*i +: ENTRY_W] = {r_slot[i], 1'b1};
    end
  end

endmodule

// File: rtl/queue_scheduler.sv
// Four input queues drained round-robin into a single registered output slot
// with valid/ready handshake; grants are decided from registered occupancy.
module queue_scheduler
  import qsched_pkg::*;
#(
  parameter int NQ    = qsched_pkg::NQ,
  parameter int DEPTH = qsched_pkg::DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [3:0]  in_data,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [1:0]  out_qid,
  output logic [1:0]  out_data,
  output logic [11:0] occ_o,
  output logic [3:0]  drop_o,
  output logic [17:0] buffer1_o,
  output logic [17:0] buffer2_o,
  output logic [17:0] buffer3_o,
  output logic [17:0] buffer4_o
);

  sched_state_e     r_state, w_state_nxt;
  logic [QID_W-1:0] r_ptr;
  logic [QID_W-1:0] r_qid;
  logic [PAY_W-1:0] r_data;

  logic [NQ-1:0]              w_pop;
  logic [NQ-1:0]              w_full;
  logic [NQ-1:0]              w_empty;
  logic [CNT_W-1:0]           w_count [NQ];
  logic [PAY_W-1:0]           w_head  [NQ];
  logic [DEPTH*ENTRY_W-1:0]   w_image [NQ];
  logic                       w_take;
  grant_t                     w_grant;

  for (genvar g = 0; g < NQ; g++) begin : g_queue
    shift_queue #(.DEPTH(DEPTH)) u_queue (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (in_valid && (in_data[3:2] == QID_W'(g))),
      .i_data  (in_data[1:0]),
      .i_pop   (w_pop[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g]),
      .o_count (w_count[g]),
      .o_head  (w_head[g]),
      .o_image (w_image[g]),
      .o_drop  (drop_o[g])
    );
    assign occ_o[CNT_W*g +: CNT_W] = w_count[g];

    always_comb assert (!(w_full[g] && w_empty[g]));
  end

  assign buffer1_o = w_image[0];
  assign buffer2_o = w_image[1];
  assign buffer3_o = w_image[2];
  assign buffer4_o = w_image[3];

  assign w_grant = rr_pick(~w_empty, r_ptr);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = '0;
    w_take      = 1'b0;
    if (r_state == S_IDLE || out_ready) begin
      if (w_grant.found) begin
        w_pop[w_grant.qid] = 1'b1;
        w_take             = 1'b1;
        w_state_nxt        = S_HOLD;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  // Pointer resets to the last queue so the first grant after reset is queue 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= QID_W'(NQ - 1);
      r_qid   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_ptr  <= w_grant.qid;
        r_qid  <= w_grant.qid;
        r_data <= w_head[w_grant.qid];
      end
    end
  end

  assign out_valid = (r_state == S_HOLD);
  assign out_qid   = r_qid;
  assign out_data  = r_data;

endmodule

// File: tb/tb_queue_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic, all compared
// each cycle against a queue-based behavioural model of the scheduler.
module tb_queue_scheduler;

  localparam int MQ = 4;
  localparam int MD = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  in_data = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [1:0]  out_qid;
  logic [1:0]  out_data;
  logic [11:0] occ_o;
  logic [3:0]  drop_o;
  logic [17:0] buffer1_o, buffer2_o, buffer3_o, buffer4_o;
  logic [17:0] bufs [MQ];

  queue_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_qid   (out_qid),
    .out_data  (out_data),
    .occ_o     (occ_o),
    .drop_o    (drop_o),
    .buffer1_o (buffer1_o),
    .buffer2_o (buffer2_o),
    .buffer3_o (buffer3_o),
    .buffer4_o (buffer4_o)
  );

  always #5 clk = ~clk;

  assign bufs[0] = buffer1_o;
  assign bufs[1] = buffer2_o;
  assign bufs[2] = buffer3_o;
  assign bufs[3] = buffer4_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain FIFOs of payloads plus the output slot contents.
  logic [1:0] mq [MQ][$];
  logic       m_drop [MQ];
  int         m_ptr;
  logic       m_hold;
  logic [1:0] m_qid;
  logic [1:0] m_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int q = 0; q < MQ; q++) begin
      mq[q].delete();
      m_drop[q] = 1'b0;
    end
    m_ptr  = MQ - 1;
    m_hold = 1'b0;
    m_qid  = '0;
    m_data = '0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] d, input logic rdy);
    int pick;
    int q;
    if (!m_hold || rdy) begin
      pick = -1;
      for (int k = 1; k <= MQ; k++) begin
        q = (m_ptr + k) % MQ;
        if (pick < 0 && mq[q].size() > 0) pick = q;
      end
      if (pick >= 0) begin
        m_qid  = 2'(pick);
        m_data = mq[pick].pop_front();
        m_hold = 1'b1;
        m_ptr  = pick;
      end else begin
        m_hold = 1'b0;
      end
    end
    if (v) begin
      q = int'(d[3:2]);
      if (mq[q].size() == MD) begin
        void'(mq[q].pop_front());
        m_drop[q] = 1'b1;
      end
      mq[q].push_back(d[1:0]);
    end
  endtask

  function automatic logic [17:0] exp_image(input int q);
    logic [17:0] r;
    r = '0;
    for (int i = 0; i < mq[q].size(); i++) r[3*i +: 3] = {mq[q][i], 1'b1};
    return r;
  endfunction

  task automatic compare_all();
    check("out_valid", 32'(out_valid), 32'(m_hold));
    check("out_qid", 32'(out_qid), 32'(m_qid));
    check("out_data", 32'(out_data), 32'(m_data));
    for (int q = 0; q < MQ; q++) begin
      check($sformatf("occ%0d", q), 32'(occ_o[3*q +: 3]), 32'(mq[q].size()));
      check($sformatf("drop%0d", q), 32'(drop_o[q]), 32'(m_drop[q]));
      check($sformatf("image%0d", q), 32'(bufs[q]), 32'(exp_image(q)));
    end
  endtask

  task automatic cycle(input logic v, input logic [3:0] d, input logic rdy);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    @(posedge clk);
    model_step(v, d, rdy);
    @(negedge clk);
    compare_all();
  endtask

  // Assert reset away from a clock edge; outputs must clear before any posedge.
  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_occ", 32'(occ_o), 32'd0);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();

    // Single write: visible two cycles later, then output drains.
    cycle(1'b1, 4'b0110, 1'b1);
    check("r029_early", 32'(out_valid), 32'd0);
    cycle(1'b0, 4'b0000, 1'b1);
    check("r029_valid", 32'(out_valid), 32'd1);
    check("r029_qid", 32'(out_qid), 32'd1);
    check("r029_data", 32'(out_data), 32'd2);
    cycle(1'b0, 4'b0000, 1'b1);
    check("r029_idle", 32'(out_valid), 32'd0);

    // One entry per queue: grants come out in qid order on consecutive cycles.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(i < 4, {2'(i), 2'(3 - i)}, 1'b1);
      if (i >= 1) begin
        check("r030_valid", 32'(out_valid), 32'd1);
        check("r030_qid", 32'(out_qid), 32'(i - 1));
      end
    end

    // Hold stability with out_ready low while queue 3 fills behind it.
    do_reset();
    cycle(1'b1, 4'b0011, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, {2'b10, 2'(i)}, 1'b0);
      check("r033_valid", 32'(out_valid), 32'd1);
      check("r033_qid", 32'(out_qid), 32'd0);
      check("r033_data", 32'(out_data), 32'd3);
    end
    cycle(1'b1, 4'b1001, 1'b0);
    check("q3_full", 32'(occ_o[8:6]), 32'd6);

    // Seven writes to queue 1 behind a held entry: one overflow.
    for (int i = 0; i < 7; i++) cycle(1'b1, {2'b00, 2'((i + 1) % 4)}, 1'b0);
    check("r031_occ", 32'(occ_o[2:0]), 32'd6);
    check("r031_drop", 32'(drop_o[0]), 32'd1);
    check("r031_head", 32'(buffer1_o[2:0]), 32'({2'd2, 1'b1}));
    check("r031_tail", 32'(buffer1_o[17:15]), 32'({2'd3, 1'b1}));

    // Full queue 3 popped and written on the same edge: no drop.
    cycle(1'b1, 4'b1010, 1'b1);
    check("r032_qid", 32'(out_qid), 32'd2);
    check("r032_occ", 32'(occ_o[8:6]), 32'd6);
    check("r032_drop", 32'(drop_o[2]), 32'd0);

    // Reset mid-operation, then the first grant must go to queue 1.
    do_reset();
    cycle(1'b1, 4'b0001, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);
    check("r034_qid", 32'(out_qid), 32'd0);
    check("r034_valid", 32'(out_valid), 32'd1);

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(499) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(9) < 7, 4'($urandom), $urandom_range(9) < 5);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
